gcd_ctrl: RTL and testbench

- Control FSM for the subtractive GCD datapath. It drives the datapath's mux selects, register enables and output-register enable, and consumes its x_lt_y / x_ne_y status.
- Presents a start/ready/done handshake to the host.
- Bounds each run with an iteration watchdog, so degenerate operands (a zero operand) terminate with an error instead of hanging.

---
 rtl/gcd_pkg.sv | 16 +
 rtl/gcd_ctrl_if.sv | 32 +++
 rtl/gcd_iter_cnt.sv | 32 +++
 rtl/gcd_ctrl.sv | 106 ++++++++++
 tb/tb_gcd_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_pkg.sv
// Shared types and mux-select encodings for the subtractive GCD controller
// and its datapath.
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    DONE,
    ERR
  } gcd_state_t;

  localparam logic SEL_EXT = 1'b0;
  localparam logic SEL_SUB = 1'b1;

endpackage

// File: rtl/gcd_ctrl_if.sv
// Host handshake plus datapath control/status bundle between the GCD
// controller (slave) and its environment (master).
interface gcd_ctrl_if #(
  parameter int ITER_W = 16
);

  logic              start;
  logic              abort;
  logic              x_lt_y;
  logic              x_ne_y;
  logic              ready;
  logic              busy;
  logic              done;
  logic              err;
  logic              x_sel;
  logic              x_en;
  logic              y_sel;
  logic              y_en;
  logic              output_en;
  logic [ITER_W-1:0] iter_count;

  modport master (
    output start, abort, x_lt_y, x_ne_y,
    input  ready, busy, done, err, x_sel, x_en, y_sel, y_en, output_en, iter_count
  );

  modport slave (
    input  start, abort, x_lt_y, x_ne_y,
    output ready, busy, done, err, x_sel, x_en, y_sel, y_en, output_en, iter_count
  );

endinterface

// File: rtl/gcd_iter_cnt.sv
// Saturating subtract-step counter; clear wins over increment and the count
// never wraps past MAX_ITER.
module gcd_iter_cnt #(
  parameter int ITER_W   = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ITER_W-1:0] count,
  output logic              at_max
);

  localparam logic [ITER_W-1:0] MAX_VAL = ITER_W'(MAX_ITER);

  logic [ITER_W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && !at_max) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign at_max = (count_reg == MAX_VAL);
  assign count  = count_reg;

endmodule

// File: rtl/gcd_ctrl.sv
// Control FSM for the subtractive GCD datapath: start/ready/done handshake,
// Mealy datapath controls and an iteration watchdog that ends runs with err.
module gcd_ctrl
  import gcd_pkg::*;
#(
  parameter int MAX_ITER = 65535,
  parameter int ITER_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  gcd_ctrl_if.slave  bus
);

  gcd_state_t        state_reg;
  gcd_state_t        state_next;
  logic              cnt_clr;
  logic              cnt_inc;
  logic              cnt_at_max;
  logic [ITER_W-1:0] cnt_value;

  gcd_iter_cnt #(
    .ITER_W   (ITER_W),
    .MAX_ITER (MAX_ITER)
  ) u_iter_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .count  (cnt_value),
    .at_max (cnt_at_max)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bus.ready     = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    bus.x_sel     = SEL_EXT;
    bus.y_sel     = SEL_EXT;
    bus.x_en      = 1'b0;
    bus.y_en      = 1'b0;
    bus.output_en = 1'b0;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;

    unique case (state_reg)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) begin
          bus.x_en   = 1'b1;
          bus.y_en   = 1'b1;
          cnt_clr    = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        // Status inputs reflect the freshly loaded operands only from here on.
        bus.busy   = 1'b1;
        state_next = CALC;
      end
      CALC: begin
        bus.busy = 1'b1;
        if (bus.abort) begin
          state_next = IDLE;
        end else if (!bus.x_ne_y) begin
          bus.output_en = 1'b1;
          state_next    = DONE;
        end else if (cnt_at_max) begin
          state_next = ERR;
        end else if (bus.x_lt_y) begin
          bus.y_sel = SEL_SUB;
          bus.y_en  = 1'b1;
          cnt_inc   = 1'b1;
        end else begin
          bus.x_sel = SEL_SUB;
          bus.x_en  = 1'b1;
          cnt_inc   = 1'b1;
        end
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        bus.done   = 1'b1;
        bus.err    = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.iter_count = cnt_value;

endmodule

// File: tb/tb_gcd_ctrl.sv
// End-to-end bench: gcd_ctrl driving a 16-bit subtractive datapath, with a
// Euclid-based reference model feeding a scoreboard checked at each done.
module tb_gcd_ctrl;

  localparam int MAX    = 16;
  localparam int ITER_W = 16;
  localparam int WIDTH  = 16;

  typedef struct {
    int res;
    int iter;
    bit err;
  } exp_t;

  logic clk;
  logic rst;
  logic [WIDTH-1:0] a_op, b_op;
  logic [WIDTH-1:0] x_reg, y_reg, out_data;

  int   checks = 0;
  int   errors = 0;
  int   last_result = 0;
  exp_t sb[$];

  gcd_ctrl_if #(.ITER_W(ITER_W)) bus ();

  gcd_ctrl #(
    .MAX_ITER (MAX),
    .ITER_W   (ITER_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Datapath: operand/subtractor muxes, X/Y registers, result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg    <= '0;
      y_reg    <= '0;
      out_data <= '0;
    end else begin
      if (bus.x_en)      x_reg    <= bus.x_sel ? (x_reg - y_reg) : a_op;
      if (bus.y_en)      y_reg    <= bus.y_sel ? (y_reg - x_reg) : b_op;
      if (bus.output_en) out_data <= x_reg;
    end
  end

  assign bus.x_lt_y = (x_reg < y_reg);
  assign bus.x_ne_y = (x_reg != y_reg);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: subtract-step count equals the sum of Euclid quotients minus one.
  task automatic model(input int a, input int b, output exp_t e);
    int x, y, q, s;
    e.err = 1'b0;
    if (a == b) begin
      e.res  = a;
      e.iter = 0;
    end else if (a == 0 || b == 0) begin
      e.err  = 1'b1;
      e.iter = MAX;
    end else begin
      x = a; y = b; s = 0;
      while (y != 0) begin
        q = x / y;
        s += q;
        q = x % y;
        x = y;
        y = q;
      end
      e.res  = x;
      e.iter = s - 1;
      if (e.iter > MAX) begin
        e.err  = 1'b1;
        e.iter = MAX;
      end
    end
    if (e.err) e.res = last_result;
    else       last_result = e.res;
  endtask

  // Monitor: per-cycle exclusivity and scoreboard comparison on done.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.busy) check("xy_en_exclusive", 32'(bus.x_en && bus.y_en), 0);
      check("out_en_exclusive", 32'(bus.output_en && (bus.x_en || bus.y_en)), 0);
      if (bus.err && !bus.done) check("err_without_done", 1, 0);
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("done_err", 32'(bus.err), 32'(e.err));
          check("done_result", 32'(out_data), 32'(e.res));
          check("done_iter", 32'(bus.iter_count), 32'(e.iter));
          $display("run done err=%0d result=%0d iter=%0d", bus.err, out_data, bus.iter_count);
        end
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!bus.ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!bus.ready) check("ready_timeout", 0, 1);
  endtask

  task automatic run(input int a, input int b, output int lat);
    exp_t e;
    int   k, en;
    bit   seen;
    wait_ready();
    a_op = WIDTH'(a);
    b_op = WIDTH'(b);
    bus.start = 1'b1;
    model(a, b, e);
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    k = 1; en = 0; seen = 0; lat = -1;
    while (!seen && k <= MAX + 20) begin
      if (bus.busy && (bus.x_en || bus.y_en)) en++;
      if (bus.done) begin
        seen = 1;
        lat  = k;
      end else begin
        @(negedge clk);
        k++;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    check("run_latency", lat, e.iter + 3);
    check("run_sub_steps", en, e.iter);
    $display("run a=%0d b=%0d latency=%0d steps=%0d", a, b, lat, en);
    @(negedge clk);
  endtask

  task automatic abort_run(input int a, input int b, input int n);
    wait_ready();
    a_op = WIDTH'(a);
    b_op = WIDTH'(b);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (n) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_ready", 32'(bus.ready), 1);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_iter", 32'(bus.iter_count), n - 1);
    $display("abort a=%0d b=%0d in CALC %0d iter=%0d", a, b, n, bus.iter_count);
    @(negedge clk);
  endtask

  initial begin
    int lat, k, idle;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    a_op = '0;
    b_op = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.ready), 1);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done_err", 32'({bus.done, bus.err}), 0);
    check("rst_enables", 32'({bus.x_sel, bus.x_en, bus.y_sel, bus.y_en, bus.output_en}), 0);
    check("rst_iter", 32'(bus.iter_count), 0);
    rst = 1'b0;
    @(negedge clk);

    run(12, 8, lat);
    check("basic_done_cycle", lat, 5);
    run(7, 7, lat);
    run(0, 5, lat);
    run(5, 0, lat);
    run(0, 0, lat);
    abort_run(100, 3, 3);

    // Asynchronous reset mid-run.
    wait_ready();
    a_op = 16'd100;
    b_op = 16'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_ready", 32'(bus.ready), 1);
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_enables", 32'({bus.x_en, bus.y_en, bus.output_en}), 0);
    check("midrst_iter", 32'(bus.iter_count), 0);
    last_result = 0;
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_after_done", 32'(bus.done), 0);
    $display("mid-run reset ready=%0d iter=%0d", bus.ready, bus.iter_count);

    // Back-to-back runs with start held high.
    begin
      exp_t e;
      wait_ready();
      a_op = 16'd9;
      b_op = 16'd6;
      bus.start = 1'b1;
      model(9, 6, e);
      sb.push_back(e);
      @(negedge clk);
      a_op = 16'd35;
      b_op = 16'd14;
      model(35, 14, e);
      sb.push_back(e);
      k = 0;
      while (!bus.done && k < 50) begin
        @(negedge clk);
        k++;
      end
      check("b2b_first_done", 32'(bus.done), 1);
      @(negedge clk);
      k = 0; idle = 0;
      while (!bus.busy && k < 10) begin
        if (bus.ready) idle++;
        @(negedge clk);
        k++;
      end
      check("b2b_idle_cycles", idle, 1);
      k = 0;
      while (!bus.done && k < 50) begin
        @(negedge clk);
        k++;
      end
      check("b2b_second_done", 32'(bus.done), 1);
      bus.start = 1'b0;
      $display("back-to-back idle=%0d", idle);
      @(negedge clk);
    end

    for (int i = 0; i < 25; i++) begin
      int a, b;
      a = $urandom_range(0, 40);
      b = ($urandom_range(0, 4) == 0) ? a : $urandom_range(0, 40);
      run(a, b, lat);
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
